// File: rtl/accumulator_mcu_gen2_pkg.sv
// Shared encodings for the second-generation accumulator MCU: FSM states,
// major opcodes and the sub-operations of the misc opcode.
package accumulator_mcu_gen2_pkg;

    typedef enum logic [1:0] {
        ST_FETCH    = 2'b00,
        ST_EXEC     = 2'b01,
        ST_HALT     = 2'b10,
        ST_HALT_ALT = 2'b11
    } state_t;

    localparam logic [2:0] OP_LDA  = 3'b000;
    localparam logic [2:0] OP_STA  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_JMP  = 3'b100;
    localparam logic [2:0] OP_JZ   = 3'b101;
    localparam logic [2:0] OP_CALL = 3'b110;
    localparam logic [2:0] OP_MISC = 3'b111;

    localparam int SUB_RET = 0;
    localparam int SUB_HLT = 1;
    localparam int SUB_CLR = 2;
    localparam int SUB_NOT = 3;
    localparam int SUB_SHL = 4;
    localparam int SUB_SHR = 5;

endpackage

// File: rtl/accumulator_mcu_gen2_scan_reg.sv
// Loadable register with a serial scan path; shifts LSB-first toward scan_out.
// Non-resettable instances (memory words) simply hold through reset.
module accumulator_mcu_gen2_scan_reg #(
    parameter int WIDTH      = 8,
    parameter bit RESETTABLE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scan_enable,
    input  logic             scan_in,
    input  logic             load_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             scan_out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            if (RESETTABLE) q <= '0;
        end else if (scan_enable) begin
            q <= {scan_in, q[WIDTH-1:1]};
        end else if (load_en) begin
            q <= d;
        end
    end

    assign scan_out = q[0];

endmodule

// File: rtl/accumulator_mcu_gen2.sv
// Single-accumulator CPU with flop memory, memory-mapped button/LED port,
// carry flag, return-address stack and a full-state scan chain.
//
// state    | meaning
// FETCH    | IR <= M[PC]
// EXEC     | execute IR, then FETCH (or HALT on HLT / stack fault)
// HALT     | frozen until rst or a scan load of the state field
// HALT_ALT | unused encoding, behaves as HALT
module accumulator_mcu_gen2
    import accumulator_mcu_gen2_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 5,
    parameter int MEM_DEPTH   = 32,
    parameter int STACK_DEPTH = 4,
    parameter int IO_W        = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            scan_enable,
    input  logic            scan_in,
    output logic            scan_out,
    input  logic            proc_en,
    input  logic [IO_W-1:0] btn_in,
    output logic [IO_W-1:0] led_out,
    output logic            halt,
    output logic            fault
);

    localparam int SP_W      = $clog2(STACK_DEPTH + 1);
    localparam int STK_IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int IO_ADDR   = MEM_DEPTH - 1;

    state_t              state_q, state_d;
    logic [1:0]          state_bits;
    logic [ADDR_W-1:0]   pc_q, pc_d, pc_inc;
    logic [DATA_W-1:0]   ir_q, ir_d, acc_q, acc_d;
    logic                c_q, c_d;
    logic [SP_W-1:0]     sp_q, sp_d, sp_dec;
    logic                fault_d;
    logic [ADDR_W-1:0]   stack_q [STACK_DEPTH];
    logic                push, mem_we, led_we;
    logic                exec_en;
    logic [2:0]          op;
    logic [ADDR_W-1:0]   opa;
    logic [DATA_W-1:0]   rd_pc, rd_a;
    logic [DATA_W-1:0]   mem_q [MEM_DEPTH];
    logic [MEM_DEPTH:0]  mem_chain;
    logic                pc_so, ir_so, acc_so;

    assign exec_en    = proc_en & ~scan_enable;
    assign state_bits = state_q;
    assign op         = ir_q[DATA_W-1 -: 3];
    assign opa        = ir_q[ADDR_W-1:0];
    assign pc_inc     = pc_q + ADDR_W'(1);
    assign sp_dec     = sp_q - SP_W'(1);
    assign halt       = (state_q == ST_HALT) || (state_q == ST_HALT_ALT);

    // The I/O address reads the buttons; out-of-range addresses read zero.
    always_comb begin
        rd_pc = '0;
        if (int'(pc_q) == IO_ADDR)      rd_pc = DATA_W'(btn_in);
        else if (int'(pc_q) < MEM_DEPTH) rd_pc = mem_q[pc_q];
    end

    always_comb begin
        rd_a = '0;
        if (int'(opa) == IO_ADDR)      rd_a = DATA_W'(btn_in);
        else if (int'(opa) < MEM_DEPTH) rd_a = mem_q[opa];
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        c_d     = c_q;
        sp_d    = sp_q;
        fault_d = fault;
        push    = 1'b0;
        mem_we  = 1'b0;
        led_we  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ir_d    = rd_pc;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
                case (op)
                    OP_LDA: acc_d = rd_a;
                    OP_STA: begin
                        mem_we = (int'(opa) < MEM_DEPTH);
                        led_we = (int'(opa) == IO_ADDR);
                    end
                    OP_ADD: {c_d, acc_d} = {1'b0, acc_q} + {1'b0, rd_a};
                    OP_SUB: {c_d, acc_d} = {1'b0, acc_q} - {1'b0, rd_a};
                    OP_JMP: pc_d = opa;
                    OP_JZ:  if (acc_q == '0) pc_d = opa;
                    OP_CALL: begin
                        if (sp_q == SP_W'(STACK_DEPTH)) begin
                            fault_d = 1'b1;
                            state_d = ST_HALT;
                            pc_d    = pc_q;
                        end else begin
                            push = 1'b1;
                            sp_d = sp_q + SP_W'(1);
                            pc_d = opa;
                        end
                    end
                    OP_MISC: begin
                        case (int'(opa))
                            SUB_RET: begin
                                if (sp_q == '0) begin
                                    fault_d = 1'b1;
                                    state_d = ST_HALT;
                                    pc_d    = pc_q;
                                end else begin
                                    sp_d = sp_dec;
                                    pc_d = stack_q[sp_dec[STK_IDX_W-1:0]];
                                end
                            end
                            SUB_HLT: begin
                                state_d = ST_HALT;
                                pc_d    = pc_q;
                            end
                            SUB_CLR: begin
                                acc_d = '0;
                                c_d   = 1'b0;
                            end
                            SUB_NOT: acc_d = ~acc_q;
                            SUB_SHL: {c_d, acc_d} = {acc_q, 1'b0};
                            SUB_SHR: {acc_d, c_d} = {1'b0, acc_q};
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Scan order from scan_in: state, PC, IR, ACC, C, M[0..MEM_DEPTH-1].
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            c_q     <= 1'b0;
        end else if (scan_enable) begin
            state_q <= state_t'({scan_in, state_bits[1]});
            c_q     <= acc_so;
        end else if (proc_en) begin
            state_q <= state_d;
            c_q     <= c_d;
        end
    end

    // Stack, SP, fault and LEDs sit outside the chain and hold during scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q    <= '0;
            fault   <= 1'b0;
            led_out <= '0;
            for (int k = 0; k < STACK_DEPTH; k++) stack_q[k] <= '0;
        end else if (exec_en) begin
            sp_q  <= sp_d;
            fault <= fault_d;
            if (led_we) led_out <= acc_q[IO_W-1:0];
            if (push) stack_q[sp_q[STK_IDX_W-1:0]] <= pc_inc;
        end
    end

    accumulator_mcu_gen2_scan_reg #(.WIDTH(ADDR_W), .RESETTABLE(1'b1)) u_pc (
        .clk(clk), .rst(rst), .scan_enable(scan_enable), .scan_in(state_bits[0]),
        .load_en(exec_en), .d(pc_d), .q(pc_q), .scan_out(pc_so)
    );

    accumulator_mcu_gen2_scan_reg #(.WIDTH(DATA_W), .RESETTABLE(1'b1)) u_ir (
        .clk(clk), .rst(rst), .scan_enable(scan_enable), .scan_in(pc_so),
        .load_en(exec_en), .d(ir_d), .q(ir_q), .scan_out(ir_so)
    );

    accumulator_mcu_gen2_scan_reg #(.WIDTH(DATA_W), .RESETTABLE(1'b1)) u_acc (
        .clk(clk), .rst(rst), .scan_enable(scan_enable), .scan_in(ir_so),
        .load_en(exec_en), .d(acc_d), .q(acc_q), .scan_out(acc_so)
    );

    assign mem_chain[0] = c_q;

    for (genvar i = 0; i < MEM_DEPTH; i++) begin : g_mem
        accumulator_mcu_gen2_scan_reg #(.WIDTH(DATA_W), .RESETTABLE(1'b0)) u_word (
            .clk(clk), .rst(rst), .scan_enable(scan_enable), .scan_in(mem_chain[i]),
            .load_en(exec_en && mem_we && (int'(opa) == i)),
            .d(acc_q), .q(mem_q[i]), .scan_out(mem_chain[i+1])
        );
    end

    assign scan_out = mem_chain[MEM_DEPTH];

endmodule

// File: tb/tb_accumulator_mcu_gen2.sv
// Self-checking bench for accumulator_mcu_gen2: directed program scenarios plus
// random programs compared against an instruction-level reference model.
module tb_accumulator_mcu_gen2;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int MD    = 32;
    localparam int SD    = 4;
    localparam int IW    = 7;
    localparam int HDR   = 3 + AW + 2 * DW;
    localparam int CHAIN = 3 + AW + DW * (MD + 2);
    localparam int DMOD  = 1 << DW;

    logic          clk = 1'b0;
    logic          rst, scan_enable, scan_in, scan_out, proc_en, halt, fault;
    logic [IW-1:0] btn_in, led_out;

    always #5 clk = ~clk;

    accumulator_mcu_gen2 #(
        .DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(MD), .STACK_DEPTH(SD), .IO_W(IW)
    ) dut (
        .clk(clk), .rst(rst), .scan_enable(scan_enable), .scan_in(scan_in),
        .scan_out(scan_out), .proc_en(proc_en), .btn_in(btn_in),
        .led_out(led_out), .halt(halt), .fault(fault)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // scan image written into the chain, and image read back out of it
    logic [1:0]    i_state, o_state;
    logic [AW-1:0] i_pc, o_pc;
    logic [DW-1:0] i_ir, i_acc, o_ir, o_acc;
    logic          i_c, o_c;
    logic [DW-1:0] i_mem [MD];
    logic [DW-1:0] o_mem [MD];

    // reference model: one call executes one whole instruction
    int m_mem [MD];
    int m_pc, m_acc, m_c, m_fault, m_halt, m_led, m_btn;
    int m_stk [$];

    task automatic clear_img();
        i_state = '0; i_pc = '0; i_ir = '0; i_acc = '0; i_c = 1'b0;
        for (int i = 0; i < MD; i++) i_mem[i] = '0;
    endtask

    task automatic scan_xfer(input logic [CHAIN-1:0] din, output logic [CHAIN-1:0] dout);
        for (int j = 0; j < CHAIN; j++) begin
            @(negedge clk);
            dout[j]     = scan_out;
            scan_in     = din[j];
            scan_enable = 1'b1;
        end
        @(negedge clk);
        scan_enable = 1'b0;
        scan_in     = 1'b0;
    endtask

    task automatic scan_img();
        logic [CHAIN-1:0] v, d;
        v = '0;
        v[CHAIN-1 -: HDR] = {i_state, i_pc, i_ir, i_acc, i_c};
        for (int i = 0; i < MD; i++) v[DW*(MD-i)-1 -: DW] = i_mem[i];
        scan_xfer(v, d);
        {o_state, o_pc, o_ir, o_acc, o_c} = d[CHAIN-1 -: HDR];
        for (int i = 0; i < MD; i++) o_mem[i] = d[DW*(MD-i)-1 -: DW];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; proc_en = 1'b0; scan_enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic model_load();
        for (int i = 0; i < MD; i++) m_mem[i] = int'(i_mem[i]);
        m_pc = int'(i_pc); m_acc = int'(i_acc); m_c = int'(i_c);
        m_fault = 0; m_halt = 0; m_led = 0; m_btn = int'(btn_in);
        m_stk.delete();
    endtask

    function automatic int m_rd(input int addr);
        if (addr == MD - 1) return m_btn;
        if (addr < MD) return m_mem[addr];
        return 0;
    endfunction

    task automatic model_step();
        int ir, op, a, v, s, npc;
        if (m_halt != 0) return;
        ir  = m_rd(m_pc);
        op  = ir >> (DW - 3);
        a   = ir % (1 << AW);
        v   = m_rd(a);
        npc = (m_pc + 1) % (1 << AW);
        case (op)
            0: m_acc = v;
            1: begin
                if (a < MD) m_mem[a] = m_acc;
                if (a == MD - 1) m_led = m_acc % (1 << IW);
            end
            2: begin s = m_acc + v; m_c = (s >= DMOD) ? 1 : 0; m_acc = s % DMOD; end
            3: begin m_c = (m_acc < v) ? 1 : 0; m_acc = (m_acc - v + DMOD) % DMOD; end
            4: npc = a;
            5: if (m_acc == 0) npc = a;
            6: begin
                if (m_stk.size() == SD) begin m_fault = 1; m_halt = 1; npc = m_pc; end
                else begin m_stk.push_back(npc); npc = a; end
            end
            default: begin
                case (a)
                    0: begin
                        if (m_stk.size() == 0) begin m_fault = 1; m_halt = 1; npc = m_pc; end
                        else npc = m_stk.pop_back();
                    end
                    1: begin m_halt = 1; npc = m_pc; end
                    2: begin m_acc = 0; m_c = 0; end
                    3: m_acc = DMOD - 1 - m_acc;
                    4: begin m_c = (m_acc >= DMOD / 2) ? 1 : 0; m_acc = (m_acc * 2) % DMOD; end
                    5: begin m_c = m_acc % 2; m_acc = m_acc / 2; end
                    default: ;
                endcase
            end
        endcase
        m_pc = npc;
    endtask

    task automatic check_model(input string tg);
        check_val({tg, ".pc"},    32'(dut.pc_q),  m_pc);
        check_val({tg, ".acc"},   32'(dut.acc_q), m_acc);
        check_val({tg, ".c"},     32'(dut.c_q),   m_c);
        check_val({tg, ".sp"},    32'(dut.sp_q),  m_stk.size());
        check_val({tg, ".fault"}, 32'(fault),     m_fault);
        check_val({tg, ".halt"},  32'(halt),      m_halt);
        check_val({tg, ".led"},   32'(led_out),   m_led);
    endtask

    // one instruction = two enabled cycles; toggle mode starts each pair disabled
    task automatic run_instr(input bit toggle, output int cycles);
        int en_cnt;
        en_cnt = 0;
        cycles = 0;
        while (en_cnt < 2 && cycles < 100) begin
            proc_en = toggle ? cycles[0] : 1'b1;
            @(negedge clk);
            if (proc_en) en_cnt++;
            cycles++;
        end
        proc_en = 1'b0;
    endtask

    task automatic step1();
        proc_en = 1'b1;
        @(negedge clk);
        proc_en = 1'b0;
    endtask

    initial begin
        int cyc, n;
        rst = 1'b1; scan_enable = 1'b0; scan_in = 1'b0; proc_en = 1'b0; btn_in = '0;
        repeat (2) @(negedge clk);
        check_val("rst.pc",    32'(dut.pc_q),    0);
        check_val("rst.ir",    32'(dut.ir_q),    0);
        check_val("rst.acc",   32'(dut.acc_q),   0);
        check_val("rst.c",     32'(dut.c_q),     0);
        check_val("rst.sp",    32'(dut.sp_q),    0);
        check_val("rst.state", 32'(dut.state_q), 0);
        check_val("rst.led",   32'(led_out),     0);
        check_val("rst.halt",  32'(halt),        0);
        check_val("rst.fault", 32'(fault),       0);
        rst = 1'b0;

        // LDA 10; ADD 11; STA 12; HLT
        clear_img();
        i_mem[0] = 8'h0A; i_mem[1] = 8'h4B; i_mem[2] = 8'h2C; i_mem[3] = 8'hE1;
        i_mem[10] = 8'd200; i_mem[11] = 8'd100;
        scan_img();
        cyc = 0;
        proc_en = 1'b1;
        while (!halt && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        proc_en = 1'b0;
        check_val("prog.halt_cycles", cyc, 8);
        scan_img();
        check_val("prog.acc",   32'(o_acc),     44);
        check_val("prog.c",     32'(o_c),       1);
        check_val("prog.m12",   32'(o_mem[12]), 44);
        check_val("prog.state", 32'(o_state),   2);

        // CALL 20 -> LDA 31; STA 31; RET
        do_reset();
        btn_in = 7'h55;
        clear_img();
        i_mem[0] = 8'hD4; i_mem[1] = 8'hE1;
        i_mem[20] = 8'h1F; i_mem[21] = 8'h3F; i_mem[22] = 8'hE0;
        scan_img();
        model_load();
        for (int s = 0; s < 4; s++) begin
            run_instr(1'b0, cyc);
            model_step();
            check_model("call");
        end
        check_val("call.led",   32'(led_out),  32'h55);
        check_val("call.pc",    32'(dut.pc_q), 1);
        check_val("call.sp",    32'(dut.sp_q), 0);
        check_val("call.fault", 32'(fault),    0);

        // nested CALLs overflow the stack on the fifth
        do_reset();
        btn_in = '0;
        clear_img();
        for (int k = 0; k < 5; k++) i_mem[k] = 8'hC0 | 8'(k + 1);
        scan_img();
        for (int s = 0; s < 4; s++) run_instr(1'b0, cyc);
        check_val("nest.sp4", 32'(dut.sp_q), 4);
        step1();
        check_val("nest.fetch_fault", 32'(fault), 0);
        check_val("nest.fetch_halt",  32'(halt),  0);
        step1();
        check_val("nest.fault", 32'(fault),    1);
        check_val("nest.halt",  32'(halt),     1);
        check_val("nest.pc",    32'(dut.pc_q), 4);

        do_reset();
        clear_img();
        i_mem[0] = 8'hE0;
        scan_img();
        run_instr(1'b0, cyc);
        check_val("ret0.fault", 32'(fault), 1);
        check_val("ret0.halt",  32'(halt),  1);

        // JZ 9 with ACC=0/1, continuous and with proc_en toggling
        for (int t = 0; t < 2; t++) begin
            for (int av = 0; av < 2; av++) begin
                do_reset();
                clear_img();
                i_mem[0] = 8'hA9;
                i_acc = DW'(av);
                scan_img();
                run_instr(t[0], cyc);
                check_val(t == 0 ? "jz.pc" : "jz_tog.pc", 32'(dut.pc_q), av == 0 ? 9 : 1);
                check_val(t == 0 ? "jz.cycles" : "jz_tog.cycles", cyc, t == 0 ? 2 : 4);
            end
        end

        // reset lands in the EXEC cycle of STA 12
        do_reset();
        clear_img();
        i_mem[0] = 8'h0A; i_mem[1] = 8'h3F; i_mem[2] = 8'h2C;
        i_mem[10] = 8'h5A; i_mem[12] = 8'h33;
        scan_img();
        run_instr(1'b0, cyc);
        run_instr(1'b0, cyc);
        check_val("rstx.led_before", 32'(led_out), 32'h5A);
        step1();
        check_val("rstx.in_exec", 32'(dut.state_q), 1);
        rst = 1'b1; proc_en = 1'b1;
        @(negedge clk);
        rst = 1'b0; proc_en = 1'b0;
        check_val("rstx.pc",    32'(dut.pc_q),    0);
        check_val("rstx.acc",   32'(dut.acc_q),   0);
        check_val("rstx.led",   32'(led_out),     0);
        check_val("rstx.state", 32'(dut.state_q), 0);
        scan_img();
        check_val("rstx.m12", 32'(o_mem[12]), 32'h33);
        check_val("rstx.m10", 32'(o_mem[10]), 32'h5A);
        check_val("rstx.m31", 32'(o_mem[31]), 32'h5A);
        check_val("rstx.m0",  32'(o_mem[0]),  32'h0A);

        // walking one through the whole chain
        do_reset();
        clear_img();
        scan_img();
        scan_enable = 1'b1; scan_in = 1'b1;
        @(negedge clk);
        scan_in = 1'b0;
        n = 1;
        while (scan_out !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        scan_enable = 1'b0;
        check_val("walk.latency", n, CHAIN);

        // random programs against the reference model
        for (int p = 0; p < 6; p++) begin
            do_reset();
            btn_in = IW'($urandom_range(0, (1 << IW) - 1));
            clear_img();
            for (int i = 0; i < MD; i++) i_mem[i] = DW'($urandom_range(0, DMOD - 1));
            i_ir  = DW'($urandom_range(0, DMOD - 1));
            i_acc = DW'($urandom_range(0, DMOD - 1));
            i_c   = 1'($urandom_range(0, 1));
            scan_img();
            model_load();
            for (int s = 0; s < 30; s++) begin
                run_instr(p[0], cyc);
                model_step();
                check_model("rand");
            end
            scan_img();
            for (int i = 0; i < MD; i++) check_val("rand.mem", 32'(o_mem[i]), m_mem[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
